// File: rtl/rheed_crop_stream_pkg.sv
// rheed_pkg: shared state encoding, beat geometry helper and pixel normalisation
package rheed_pkg;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    function automatic int ppb(input int data_width, input int pixel_width);
        return data_width / pixel_width;
    endfunction

    // MSB-aligned copy of pix cycled over the output width: replicates when widening, truncates LSBs when narrowing
    function automatic logic [31:0] norm_pixel(input logic [31:0] pix, input int ipw, input int opw);
        logic [31:0] out;
        out = '0;
        for (int j = 0; j < 32; j++)
            if (j < opw) out[opw-1-j] = pix[ipw-1-(j%ipw)];
        return out;
    endfunction

endpackage

// File: rtl/rheed_crop_stream_beat_unpacker.sv
// beat_unpacker: holds one wide input beat and presents its pixels one at a time, pixel 0 first
module beat_unpacker
    import rheed_pkg::*;
#(
    parameter int DATA_WIDTH  = 256,
    parameter int PIXEL_WIDTH = 8
) (
    input  logic                   clk,
    input  logic                   srst,
    input  logic                   i_clr,
    input  logic                   i_en,
    input  logic                   i_s_valid,
    input  logic [DATA_WIDTH-1:0]  i_s_data,
    output logic                   o_s_ready,
    output logic                   o_valid,
    output logic [PIXEL_WIDTH-1:0] o_pix,
    input  logic                   i_take,
    input  logic                   i_drop
);

    localparam int PPB = ppb(DATA_WIDTH, PIXEL_WIDTH);
    localparam int IW  = PPB > 1 ? $clog2(PPB) : 1;

    logic [DATA_WIDTH-1:0] r_data;
    logic                  r_full;
    logic [IW-1:0]         r_idx;
    logic                  w_leave;
    logic                  w_load;

    assign w_leave   = i_drop | (i_take & (r_idx == IW'(PPB-1)));
    assign o_s_ready = i_en & (~r_full | w_leave);
    assign w_load    = i_s_valid & o_s_ready;
    assign o_valid   = r_full;
    assign o_pix     = r_data[r_idx*PIXEL_WIDTH +: PIXEL_WIDTH];

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_data <= '0;
            r_full <= 1'b0;
            r_idx  <= '0;
        end else if (i_clr) begin
            r_data <= '0;
            r_full <= 1'b0;
            r_idx  <= '0;
        end else if (w_load) begin
            r_data <= i_s_data;
            r_full <= 1'b1;
            r_idx  <= '0;
        end else if (w_leave) begin
            r_full <= 1'b0;
            r_idx  <= '0;
        end else if (i_take) begin
            r_idx  <= r_idx + 1'b1;
        end
    end

endmodule

// File: rtl/rheed_crop_stream.sv
// rheed_crop_stream: unpacks wide pixel beats, crops/decimates a runtime window
// and normalises kept pixels onto a framed one-pixel-per-beat output stream.
module rheed_crop_stream
    import rheed_pkg::*;
#(
    parameter int DATA_WIDTH      = 256,
    parameter int IN_PIXEL_WIDTH  = 8,
    parameter int OUT_PIXEL_WIDTH = 10,
    parameter int IN_ROWS         = 1024,
    parameter int IN_COLS         = 1024,
    parameter int MAX_STRIDE      = 4
) (
    input  logic                               clk,
    input  logic                               srst,
    input  logic                               ap_start,
    output logic                               ap_ready,
    output logic                               ap_idle,
    output logic                               ap_done,
    input  logic [$clog2(IN_COLS)-1:0]         crop_x0,
    input  logic [$clog2(IN_ROWS)-1:0]         crop_y0,
    input  logic [$clog2(IN_COLS+1)-1:0]       crop_w,
    input  logic [$clog2(IN_ROWS+1)-1:0]       crop_h,
    input  logic [$clog2(MAX_STRIDE+1)-1:0]    stride,
    output logic                               cfg_err,
    input  logic                               s_axis_tvalid,
    output logic                               s_axis_tready,
    input  logic [DATA_WIDTH-1:0]              s_axis_tdata,
    output logic                               m_axis_tvalid,
    input  logic                               m_axis_tready,
    output logic [OUT_PIXEL_WIDTH-1:0]         m_axis_tdata,
    output logic                               m_axis_tuser,
    output logic                               m_axis_tlast
);

    localparam int PPB = ppb(DATA_WIDTH, IN_PIXEL_WIDTH);
    localparam int XW  = $clog2(IN_COLS+1) + 1;
    localparam int YW  = $clog2(IN_ROWS+1) + 1;
    localparam int SW  = $clog2(MAX_STRIDE+1);

    state_t                     r_state;
    logic [XW-1:0]              r_x0, r_x1, r_col;
    logic [YW-1:0]              r_y0, r_y1, r_row;
    logic [SW-1:0]              r_stride, r_cph, r_rph;
    logic                       r_err, r_first, r_eval_done;
    logic                       r_mvalid, r_muser, r_mlast;
    logic [OUT_PIXEL_WIDTH-1:0] r_mdata;

    logic                       w_start, w_run, w_pv;
    logic [IN_PIXEL_WIDTH-1:0]  w_pix;
    logic [XW-1:0]              w_x1, w_ncol;
    logic [YW-1:0]              w_y1;
    logic                       w_bad, w_row_in, w_col_in, w_adv, w_drop, w_take, w_keep;
    logic                       w_wrap, w_last_ev, w_last, w_fin;

    assign w_start = (r_state == IDLE) & ap_start;
    assign w_run   = r_state == RUN;
    assign w_x1    = XW'(crop_x0) + XW'(crop_w);
    assign w_y1    = YW'(crop_y0) + YW'(crop_h);
    assign w_bad   = ~|crop_w | ~|crop_h | ~|stride | (stride > SW'(MAX_STRIDE)) |
                     (w_x1 > XW'(IN_COLS)) | (w_y1 > YW'(IN_ROWS));

    // Rows outside the window or skipped by the row stride are dropped a whole beat at a time
    assign w_row_in  = ~r_err & (r_row >= r_y0) & (r_row < r_y1) & ~|r_rph;
    assign w_col_in  = (r_col >= r_x0) & (r_col < r_x1) & ~|r_cph;
    assign w_adv     = w_run & w_pv & ~r_eval_done & (~r_mvalid | m_axis_tready);
    assign w_drop    = w_adv & ~w_row_in;
    assign w_take    = w_adv & w_row_in;
    assign w_keep    = w_take & w_col_in;
    assign w_ncol    = r_col + (w_drop ? XW'(PPB) : XW'(1));
    assign w_wrap    = w_ncol == XW'(IN_COLS);
    assign w_last_ev = w_adv & w_wrap & (r_row == YW'(IN_ROWS-1));
    // Last kept pixel: no further stride step fits inside the window in either axis
    assign w_last    = (r_col + XW'(r_stride) >= r_x1) & (r_row + YW'(r_stride) >= r_y1);
    assign w_fin     = (r_eval_done | w_last_ev) & ~w_keep & (~r_mvalid | m_axis_tready);

    beat_unpacker #(
        .DATA_WIDTH (DATA_WIDTH),
        .PIXEL_WIDTH(IN_PIXEL_WIDTH)
    ) u_unpack (
        .clk      (clk),
        .srst     (srst),
        .i_clr    (w_start),
        .i_en     (w_run & ~r_eval_done),
        .i_s_valid(s_axis_tvalid),
        .i_s_data (s_axis_tdata),
        .o_s_ready(s_axis_tready),
        .o_valid  (w_pv),
        .o_pix    (w_pix),
        .i_take   (w_take),
        .i_drop   (w_drop)
    );

    always_ff @(posedge clk or posedge srst) begin
        if (srst) begin
            r_state     <= IDLE;
            r_x0        <= '0;
            r_x1        <= '0;
            r_y0        <= '0;
            r_y1        <= '0;
            r_stride    <= '0;
            r_col       <= '0;
            r_row       <= '0;
            r_cph       <= '0;
            r_rph       <= '0;
            r_err       <= 1'b0;
            r_first     <= 1'b0;
            r_eval_done <= 1'b0;
            r_mvalid    <= 1'b0;
            r_mdata     <= '0;
            r_muser     <= 1'b0;
            r_mlast     <= 1'b0;
        end else if (w_start) begin
            r_state     <= RUN;
            r_x0        <= XW'(crop_x0);
            r_x1        <= w_x1;
            r_y0        <= YW'(crop_y0);
            r_y1        <= w_y1;
            r_stride    <= stride;
            r_col       <= '0;
            r_row       <= '0;
            r_cph       <= '0;
            r_rph       <= '0;
            r_err       <= w_bad;
            r_first     <= 1'b1;
            r_eval_done <= 1'b0;
            r_mvalid    <= 1'b0;
        end else if (w_run) begin
            if (w_adv) begin
                r_col <= w_wrap ? '0 : w_ncol;
                if (w_wrap) begin
                    r_row <= r_row + 1'b1;
                    r_cph <= '0;
                    if (r_row >= r_y0) r_rph <= ~|r_rph ? r_stride - 1'b1 : r_rph - 1'b1;
                end else if (w_take && r_col >= r_x0) begin
                    r_cph <= ~|r_cph ? r_stride - 1'b1 : r_cph - 1'b1;
                end
            end
            if (w_last_ev) r_eval_done <= 1'b1;
            if (w_keep) begin
                r_mvalid <= 1'b1;
                r_mdata  <= OUT_PIXEL_WIDTH'(norm_pixel(32'(w_pix), IN_PIXEL_WIDTH, OUT_PIXEL_WIDTH));
                r_muser  <= r_first;
                r_mlast  <= w_last;
                r_first  <= 1'b0;
            end else if (m_axis_tready) begin
                r_mvalid <= 1'b0;
            end
            if (w_fin) r_state <= DONE;
        end else if (r_state == DONE) begin
            r_state <= IDLE;
        end
    end

    assign ap_ready      = r_state == IDLE;
    assign ap_idle       = r_state == IDLE;
    assign ap_done       = r_state == DONE;
    assign cfg_err       = r_err;
    assign m_axis_tvalid = r_mvalid;
    assign m_axis_tdata  = r_mdata;
    assign m_axis_tuser  = r_muser;
    assign m_axis_tlast  = r_mlast;

endmodule

// File: tb/tb_rheed_crop_stream.sv
// tb_rheed_crop_stream: scoreboard bench for the crop/normalise stream on an 8x8 Mono8 frame
module tb_rheed_crop_stream;

    localparam int DW = 32, IPW = 8, OPW = 10, R = 8, C = 8, MS = 4;
    localparam int NB = R * C / (DW / IPW);

    typedef struct packed {
        logic [OPW-1:0] d;
        logic           u;
        logic           l;
    } exp_t;

    logic clk = 1'b0, srst = 1'b1, ap_start = 1'b0;
    logic ap_ready, ap_idle, ap_done, cfg_err;
    logic [2:0] crop_x0 = '0, crop_y0 = '0, stride = '0;
    logic [3:0] crop_w = '0, crop_h = '0;
    logic s_axis_tvalid = 1'b0, s_axis_tready;
    logic [DW-1:0] s_axis_tdata = '0;
    logic m_axis_tvalid, m_axis_tready = 1'b0, m_axis_tuser, m_axis_tlast;
    logic [OPW-1:0] m_axis_tdata;

    exp_t q[$];
    int n_vec = 0, n_err = 0;

    always #5 clk = ~clk;

    rheed_crop_stream #(
        .DATA_WIDTH(DW), .IN_PIXEL_WIDTH(IPW), .OUT_PIXEL_WIDTH(OPW),
        .IN_ROWS(R), .IN_COLS(C), .MAX_STRIDE(MS)
    ) dut (
        .clk(clk), .srst(srst), .ap_start(ap_start), .ap_ready(ap_ready),
        .ap_idle(ap_idle), .ap_done(ap_done), .crop_x0(crop_x0), .crop_y0(crop_y0),
        .crop_w(crop_w), .crop_h(crop_h), .stride(stride), .cfg_err(cfg_err),
        .s_axis_tvalid(s_axis_tvalid), .s_axis_tready(s_axis_tready), .s_axis_tdata(s_axis_tdata),
        .m_axis_tvalid(m_axis_tvalid), .m_axis_tready(m_axis_tready), .m_axis_tdata(m_axis_tdata),
        .m_axis_tuser(m_axis_tuser), .m_axis_tlast(m_axis_tlast)
    );

    function automatic logic [OPW-1:0] norm8(input int v);
        logic [7:0] p;
        p = v[7:0];
        return {p, p[7:6]};
    endfunction

    function automatic logic [DW-1:0] beat_data(input int b);
        logic [DW-1:0] d;
        for (int k = 0; k < 4; k++) d[k*8 +: 8] = 8'(b * 4 + k);
        return d;
    endfunction

    function automatic bit kept(input int r, c, x0, y0, w, h, st);
        return r >= y0 && r < y0 + h && c >= x0 && c < x0 + w && (c - x0) % st == 0 && (r - y0) % st == 0;
    endfunction

    task automatic build(input int x0, y0, w, h, st);
        int total = 0, n = 0;
        exp_t e;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (kept(r, c, x0, y0, w, h, st)) total++;
        for (int r = 0; r < R; r++)
            for (int c = 0; c < C; c++)
                if (kept(r, c, x0, y0, w, h, st)) begin
                    e.d = norm8(r * 8 + c);
                    e.u = n == 0;
                    e.l = n == total - 1;
                    q.push_back(e);
                    n++;
                end
    endtask

    task automatic check_reset_outputs(input string name);
        logic [OPW+7:0] got;
        got = {ap_ready, ap_idle, ap_done, cfg_err, s_axis_tready, m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
        n_vec++;
        if (got !== {2'b11, 6'b0, {OPW{1'b0}}}) begin
            n_err++;
            $display("FAIL %s outputs got %h required %h", name, got, {2'b11, 6'b0, {OPW{1'b0}}});
        end
    endtask

    task automatic run_frame(input int x0, y0, w, h, st, input bit stall, input bit exp_err, input string name);
        int beats = 0, cyc = 0, dones = 0, outs = 0, valids = 0, n_exp;
        bit prev_stall = 1'b0, saw_sr_low = 1'b0;
        logic [OPW+2:0] prev_o;
        exp_t e, g;
        q.delete();
        if (!exp_err) build(x0, y0, w, h, st);
        n_exp = q.size();
        @(negedge clk);
        crop_x0 = 3'(x0); crop_y0 = 3'(y0); crop_w = 4'(w); crop_h = 4'(h); stride = 3'(st);
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        n_vec++;
        if (cfg_err !== exp_err) begin
            n_err++;
            $display("FAIL %s cfg_err got %0b required %0b", name, cfg_err, exp_err);
        end
        while (dones == 0 && cyc < 2000) begin
            if (cyc > 0) @(negedge clk);
            m_axis_tready = stall ? (cyc % 3 == 0) : 1'b1;
            s_axis_tvalid = beats < NB;
            s_axis_tdata  = beat_data(beats);
            #1;
            if (prev_stall) begin
                n_vec++;
                if ({m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata} !== prev_o) begin
                    n_err++;
                    $display("FAIL %s stall_hold got %h required %h", name,
                             {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata}, prev_o);
                end
            end
            if (m_axis_tvalid) valids++;
            if (s_axis_tvalid && !s_axis_tready) saw_sr_low = 1'b1;
            if (s_axis_tvalid && s_axis_tready) beats++;
            if (m_axis_tvalid && m_axis_tready) begin
                outs++;
                n_vec++;
                g = {m_axis_tdata, m_axis_tuser, m_axis_tlast};
                if (q.size() == 0) begin
                    n_err++;
                    $display("FAIL %s extra_pixel got %h required none", name, g);
                end else begin
                    e = q.pop_front();
                    if (g !== e) begin
                        n_err++;
                        $display("FAIL %s pixel%0d got d=%h u=%0b l=%0b required d=%h u=%0b l=%0b",
                                 name, outs, g.d, g.u, g.l, e.d, e.u, e.l);
                    end
                end
            end
            prev_stall = m_axis_tvalid && !m_axis_tready;
            prev_o = {m_axis_tvalid, m_axis_tuser, m_axis_tlast, m_axis_tdata};
            if (ap_done) dones++;
            cyc++;
        end
        s_axis_tvalid = 1'b0;
        n_vec++;
        if (dones != 1) begin
            n_err++;
            $display("FAIL %s ap_done got %0d pulses required 1 within budget", name, dones);
        end
        n_vec++;
        if (beats != NB) begin
            n_err++;
            $display("FAIL %s beats_accepted got %0d required %0d", name, beats, NB);
        end
        n_vec++;
        if (outs != n_exp) begin
            n_err++;
            $display("FAIL %s pixel_count got %0d required %0d", name, outs, n_exp);
        end
        if (exp_err) begin
            n_vec++;
            if (valids != 0) begin
                n_err++;
                $display("FAIL %s tvalid_cycles got %0d required 0", name, valids);
            end
        end
        if (stall) begin
            n_vec++;
            if (!saw_sr_low) begin
                n_err++;
                $display("FAIL %s s_tready_backpressure got never-low required low-while-stalled", name);
            end
        end
        @(negedge clk);
        n_vec++;
        if ({ap_idle, ap_done, m_axis_tvalid} !== 3'b100) begin
            n_err++;
            $display("FAIL %s after_done idle/done/valid got %b required 100", name, {ap_idle, ap_done, m_axis_tvalid});
        end
    endtask

    task automatic test_reset();
        srst = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_outputs("reset");
        srst = 1'b0;
        @(negedge clk);
        check_reset_outputs("post_reset_idle");
    endtask

    task automatic test_full_window();
        run_frame(0, 0, 8, 8, 1, 1'b0, 1'b0, "full_window");
    endtask

    task automatic test_crop_window();
        run_frame(2, 3, 3, 2, 1, 1'b0, 1'b0, "crop_window");
    endtask

    task automatic test_stride();
        run_frame(1, 0, 6, 4, 2, 1'b0, 1'b0, "stride2");
    endtask

    task automatic test_back_to_back_stall();
        run_frame(0, 0, 8, 8, 1, 1'b1, 1'b0, "backpressure");
    endtask

    task automatic test_cfg_error();
        run_frame(6, 0, 4, 8, 1, 1'b0, 1'b1, "cfg_error");
    endtask

    task automatic test_reset_mid_frame();
        int beats = 0, cyc = 0;
        @(negedge clk);
        crop_x0 = 0; crop_y0 = 0; crop_w = 8; crop_h = 8; stride = 1;
        ap_start = 1'b1;
        @(negedge clk);
        ap_start = 1'b0;
        while (beats < 5 && cyc < 200) begin
            if (cyc > 0) @(negedge clk);
            m_axis_tready = 1'b1;
            s_axis_tvalid = 1'b1;
            s_axis_tdata  = beat_data(beats);
            #1;
            if (s_axis_tready) beats++;
            cyc++;
        end
        n_vec++;
        if (beats != 5) begin
            n_err++;
            $display("FAIL mid_reset beats_before_reset got %0d required 5", beats);
        end
        @(negedge clk);
        s_axis_tvalid = 1'b0;
        srst = 1'b1;
        #1;
        check_reset_outputs("mid_frame_reset");
        @(negedge clk);
        srst = 1'b0;
        @(negedge clk);
        check_reset_outputs("mid_frame_reset_release");
        run_frame(0, 0, 8, 8, 1, 1'b0, 1'b0, "after_reset_full");
    endtask

    initial begin
        test_reset();
        test_full_window();
        test_crop_window();
        test_stride();
        test_back_to_back_stall();
        test_cfg_error();
        test_reset_mid_frame();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/rheed_crop_stream.md
# rheed_crop_stream

Parametrised successor to the Mono8 sequentializer and crop/normalise pair, merged into one streaming stage in the RHEED inference path between the CustomLogic pixel AXI-Stream and the inference core. It unpacks wide beats of configurable pixel width, applies a runtime crop window with optional stride decimation, and normalises each kept pixel to the inference pixel width. Output carries frame framing (start-of-frame on `tuser`, end-of-frame on `tlast`) and reports bad configurations on `cfg_err`.

## Interface
- `DATA_WIDTH`, 256: input beat width; must be a multiple of `IN_PIXEL_WIDTH`.
- `IN_PIXEL_WIDTH`, 8: packed input pixel width (8, 10, 12 or 16).
- `OUT_PIXEL_WIDTH`, 10: normalised output pixel width.
- `IN_ROWS`, 1024: input frame rows.
- `IN_COLS`, 1024: input frame columns; must be a multiple of `PPB` = `DATA_WIDTH`/`IN_PIXEL_WIDTH`.
- `MAX_STRIDE`, 4: largest decimation stride.
- `clk  in  1`: the single clock.
- `srst  in  1`: reset, asynchronous, active-high.
- `ap_start  in  1`: start one frame; sampled only in IDLE.
- `ap_ready  out  1`: high in IDLE.
- `ap_idle  out  1`: high in IDLE.
- `ap_done  out  1`: one-cycle pulse at frame end.
- `crop_x0  in  $clog2(IN_COLS)`, `crop_y0  in  $clog2(IN_ROWS)`: window origin.
- `crop_w  in  $clog2(IN_COLS+1)`, `crop_h  in  $clog2(IN_ROWS+1)`: window size.
- `stride  in  $clog2(MAX_STRIDE+1)`: decimation step, 1 to `MAX_STRIDE`.
- `cfg_err  out  1`: sticky bad-configuration flag.
- `s_axis_tvalid  in  1`, `s_axis_tready  out  1`, `s_axis_tdata  in  DATA_WIDTH`: input beats.
- `m_axis_tvalid  out  1`, `m_axis_tready  in  1`, `m_axis_tdata  out  OUT_PIXEL_WIDTH`, `m_axis_tuser  out  1`, `m_axis_tlast  out  1`: output pixels.

## Operation
- FSM states: IDLE, RUN, DONE.
  - IDLE→RUN on `ap_start`. Latch all config inputs, clear `cfg_err`.
  - RUN→DONE when the last pixel of the frame (`IN_ROWS`×`IN_COLS`) has been evaluated and the output register has drained.
  - DONE→IDLE unconditionally; `ap_done` is high during the DONE cycle.
- Config is invalid when any of these holds: `crop_w`=0, `crop_h`=0, `stride`=0, `stride`>`MAX_STRIDE`, `crop_x0`+`crop_w`>`IN_COLS`, `crop_y0`+`crop_h`>`IN_ROWS`.
  - On invalid config: `cfg_err` rises in the first RUN cycle. The full frame is still consumed, nothing is emitted, and `ap_done` still pulses.
- Unpacking:
  - Beat captured into a holding register.
  - Pixel k occupies bits [k·IPW +: IPW], pixel 0 first; pixel 0 of beat 0 is (row 0, col 0), raster order.
- Keep rule: pixel kept iff it lies inside the window, (col−x0) mod stride = 0 and (row−y0) mod stride = 0.
  - Implemented with down-counting stride phase counters, no divider.
- Evaluation rate: one pixel per cycle. A beat whose row is outside the window is dropped in one cycle.
- Normalisation:
  - OPW>IPW: bit-replicate, out = {pix, pix[IPW-1 -: OPW−IPW]}.
  - OPW<IPW: truncate LSBs.
  - OPW=IPW: pass-through.
- `m_axis_tuser` is high on the first kept pixel of the frame; `m_axis_tlast` is high on the last kept pixel.

## Timing
- Reset values: all outputs 0 except `ap_ready`=`ap_idle`=1. FSM goes to IDLE; counters and the holding register are cleared.
- Reset mid-frame: partial output is abandoned; there is no recovery of the frame.
- `s_axis_tready`:
  - High only in RUN.
  - Requires the holding register to be empty, or its last pixel to be leaving this cycle.
  - 0 in IDLE and DONE.
- Latency: first kept pixel of a beat is valid on `m_axis` 2 cycles after the `s_axis` handshake cycle.
- Output register:
  - Registered output.
  - While `m_axis_tvalid`=1 and `m_axis_tready`=0, `tdata`, `tuser` and `tlast` are held stable and evaluation stalls.
- Throughput: 1 pixel/cycle with `m_axis_tready` constantly high; no bubble between beats.
- `ap_done`: asserted 1 cycle after the final output handshake or the final pixel evaluation, whichever is later.
- `ap_start` outside IDLE is ignored.

## Structure
- Package `rheed_pkg`:
  - state enum (IDLE/RUN/DONE);
  - function `norm_pixel(pix, IPW, OPW)`;
  - localparam helper for `PPB`.
- One sub-module `beat_unpacker`: holding register, pixel index, and ready/valid toward the crop logic.
- Top level holds the FSM, row/column and stride counters, keep logic and the output register.

## Test plan
- Bench parameters: `DATA_WIDTH`=32, `IN_PIXEL_WIDTH`=8, `IN_ROWS`=`IN_COLS`=8, `OUT_PIXEL_WIDTH`=10. Pixel value = row·8+col.
- Full window x0=0, y0=0, w=8, h=8, stride=1, `m_axis_tready`=1 → 64 pixels norm(0..63). 63→0x0FC, `tuser` on first pixel, `tlast` on 64th, one `ap_done` pulse.
- x0=2, y0=3, w=3, h=2, stride=1 → 26, 27, 28, 34, 35, 36 as 0x068, 0x06C, 0x070, 0x088, 0x08C, 0x090. `tlast` on 0x090.
- x0=1, y0=0, w=6, h=4, stride=2 → values 1, 3, 5, 17, 19, 21 normalised; 6 outputs total.
- Repeat the first scenario with `m_axis_tready` high 1 cycle in 3 → identical sequence, `tdata` stable while stalled, `s_axis_tready` deasserts, no lost or duplicated pixels.
- x0=6, w=4 → `cfg_err`=1 in the first RUN cycle, `m_axis_tvalid` never rises, 16 beats accepted, `ap_done` pulses.
- Assert `srst` after 5 accepted beats → all outputs at reset values, `ap_idle`=1. A following valid frame reproduces the first scenario exactly.
